// File: rtl/cp0_reg_file.sv
// Coprocessor-0 register file: MTC0/MFC0 access, precise exception/ERET capture,
// Count/Compare timer and the interrupt request fed to the exception unit.
module cp0_reg_file #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
  parameter int unsigned COUNT_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cp0_write_en,
  input  logic        cp0_read_en,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] cp0_write_data,
  output logic [31:0] cp0_read_data,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay_slot,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic        int_req
);

  localparam logic [7:0]  ADDR_BADVADDR = 8'h40;
  localparam logic [7:0]  ADDR_COUNT    = 8'h48;
  localparam logic [7:0]  ADDR_COMPARE  = 8'h58;
  localparam logic [7:0]  ADDR_STATUS   = 8'h60;
  localparam logic [7:0]  ADDR_CAUSE    = 8'h68;
  localparam logic [7:0]  ADDR_EPC      = 8'h70;
  localparam logic [31:0] STATUS_RW_MASK = 32'h0000_FF03;
  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic [31:0]      r_epc;
  logic [31:0]      r_badvaddr;
  logic [7:0]       r_status_im;
  logic             r_status_exl;
  logic             r_status_ie;
  logic             r_cause_bd;
  logic             r_cause_ti;
  logic [5:0]       r_cause_ip_hw;
  logic [1:0]       r_cause_ip_sw;
  logic [4:0]       r_cause_exc_code;

  logic w_div_wrap;
  logic w_wr_count;
  logic w_wr_compare;
  logic w_wr_status;
  logic w_wr_cause;
  logic w_wr_epc;
  logic w_ti_next;
  logic w_exc_first;
  logic w_exc_addr_err;
  logic [7:0] w_ip;

  // An exception owns Status/Cause/EPC for its cycle, ERET owns Status;
  // a colliding MTC0 to those registers is dropped, others still commit.
  assign w_wr_count   = cp0_write_en && (cp0_addr == ADDR_COUNT);
  assign w_wr_compare = cp0_write_en && (cp0_addr == ADDR_COMPARE);
  assign w_wr_status  = cp0_write_en && (cp0_addr == ADDR_STATUS) && !exc_valid && !eret;
  assign w_wr_cause   = cp0_write_en && (cp0_addr == ADDR_CAUSE) && !exc_valid;
  assign w_wr_epc     = cp0_write_en && (cp0_addr == ADDR_EPC) && !exc_valid;

  assign w_exc_first    = exc_valid && !r_status_exl;
  assign w_exc_addr_err = (exc_code == 5'd4) || (exc_code == 5'd5);
  assign w_div_wrap     = (r_div == DIV_LAST);

  // Compare write beats a simultaneous match so software can always clear TI.
  assign w_ti_next = w_wr_compare ? 1'b0 :
                     (r_count == r_compare) ? 1'b1 : r_cause_ti;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_div_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_compare <= '0;
    end else begin
      if (w_wr_count) begin
        r_count <= cp0_write_data;
      end else if (w_div_wrap) begin
        r_count <= r_count + 32'd1;
      end
      if (w_wr_compare) begin
        r_compare <= cp0_write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status_im  <= RESET_STATUS[15:8];
      r_status_exl <= RESET_STATUS[1];
      r_status_ie  <= RESET_STATUS[0];
    end else begin
      if (exc_valid) begin
        r_status_exl <= 1'b1;
      end else if (eret) begin
        r_status_exl <= 1'b0;
      end else if (w_wr_status) begin
        r_status_exl <= cp0_write_data[1];
      end
      if (w_wr_status) begin
        r_status_im <= cp0_write_data[15:8];
        r_status_ie <= cp0_write_data[0];
      end
    end
  end

  // IP7 tracks the post-edge TI so TI and IP7 always read consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cause_bd       <= 1'b0;
      r_cause_ti       <= 1'b0;
      r_cause_ip_hw    <= '0;
      r_cause_ip_sw    <= '0;
      r_cause_exc_code <= '0;
    end else begin
      r_cause_ti    <= w_ti_next;
      r_cause_ip_hw <= {hw_int[5] | w_ti_next, hw_int[4:0]};
      if (w_wr_cause) begin
        r_cause_ip_sw <= cp0_write_data[9:8];
      end
      if (exc_valid) begin
        r_cause_exc_code <= exc_code;
      end
      if (w_exc_first) begin
        r_cause_bd <= exc_in_delay_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      if (w_exc_first) begin
        r_epc <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
      end else if (w_wr_epc) begin
        r_epc <= cp0_write_data;
      end
      if (exc_valid && w_exc_addr_err) begin
        r_badvaddr <= exc_badvaddr;
      end
    end
  end

  assign status_out = (RESET_STATUS & ~STATUS_RW_MASK) |
                      {16'h0000, r_status_im, 6'b000000, r_status_exl, r_status_ie};
  assign cause_out  = {r_cause_bd, r_cause_ti, 14'h0000, r_cause_ip_hw, r_cause_ip_sw,
                       1'b0, r_cause_exc_code, 2'b00};
  assign epc_out    = r_epc;

  assign w_ip    = {r_cause_ip_hw, r_cause_ip_sw};
  assign int_req = r_status_ie && !r_status_exl && (|(w_ip & r_status_im));

  always_comb begin
    cp0_read_data = '0;
    if (cp0_read_en) begin
      case (cp0_addr)
        ADDR_BADVADDR: cp0_read_data = r_badvaddr;
        ADDR_COUNT:    cp0_read_data = r_count;
        ADDR_COMPARE:  cp0_read_data = r_compare;
        ADDR_STATUS:   cp0_read_data = status_out;
        ADDR_CAUSE:    cp0_read_data = cause_out;
        ADDR_EPC:      cp0_read_data = r_epc;
        default:       cp0_read_data = '0;
      endcase
    end
  end

endmodule

// File: doc/cp0_reg_file.md
Name: cp0_reg_file

Overview:
- Coprocessor-0 register file that services the MTC0/MFC0 requests decoded in ID and carried down the pipeline.
- Also records precise exceptions and ERET from the commit point, and runs the Count/Compare timer.
- Raises the interrupt request consumed by the exception unit.
- Sits beside the MEM/commit stage. Read data returns to the EX/MEM result mux.

Parameters:
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1).
- COUNT_DIV, 2, Count increments once per COUNT_DIV cycles (power of two, ≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- cp0_write_en  input  1  MTC0 commit strobe.
- cp0_read_en  input  1  MFC0 read strobe.
- cp0_addr  input  8  {rd[4:0], sel[2:0]}.
- cp0_write_data  input  32  MTC0 data.
- cp0_read_data  output  32  MFC0 result.
- exc_valid  input  1  exception commits this cycle.
- exc_code  input  5  ExcCode value.
- exc_pc  input  32  PC of the faulting instruction.
- exc_in_delay_slot  input  1  faulting instruction is in a branch delay slot.
- exc_badvaddr  input  32  faulting address (AdEL/AdES).
- eret  input  1  ERET commits this cycle.
- hw_int  input  6  external interrupt lines (level, already synchronous).
- status_out  output  32  Status register.
- cause_out  output  32  Cause register.
- epc_out  output  32  EPC register (ERET target).
- int_req  output  1  interrupt pending and enabled.

Behaviour:
- Implemented registers (addr hex):
  - BadVAddr 8'h40
  - Count 8'h48
  - Compare 8'h58
  - Status 8'h60
  - Cause 8'h68
  - EPC 8'h70
- Any other address: reads 0, writes ignored.
- Reset (async, rst_n=0):
  - Status=RESET_STATUS; Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0; divider=0.
  - Outputs follow: cp0_read_data=0, int_req=0.
- Read: cp0_read_data is combinational from the current register contents when cp0_read_en=1, else 0. No forwarding of a same-cycle write; cp0_write_en and cp0_read_en are never both 1.
- Write: takes effect at the next rising edge. Writable fields:
  - Status IM[15:8], EXL[1], IE[0]. All other Status bits are read-only and hold their reset values.
  - Cause IP[9:8] (software interrupts) only.
  - BadVAddr read-only.
  - Count, Compare, EPC fully writable.
- Cause hardware fields, updated every cycle:
  - IP[15:10] = {hw_int[5] | TI, hw_int[4:0]}.
  - TI = bit 30.
  - BD = bit 31; ExcCode = bits [6:2].
- Timer:
  - The divider counts 0..COUNT_DIV-1. Count increments when the divider wraps, and wraps 32'hFFFF_FFFF→0.
  - When Count==Compare (registered compare, evaluated every cycle), TI is set to 1 and is sticky.
  - A Compare write clears TI in the same edge.
  - A Count write overrides that cycle's increment.
- Exception (exc_valid=1), applied at the edge:
  - If Status.EXL=0: EPC←exc_in_delay_slot ? exc_pc−4 : exc_pc, and Cause.BD←exc_in_delay_slot.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: EXL←1 and ExcCode←exc_code.
  - If exc_code is 4 (AdEL) or 5 (AdES): BadVAddr←exc_badvaddr.
- ERET (eret=1): Status.EXL←0.
- Same-cycle priority: exc_valid > eret > cp0_write_en. The lower-priority event is dropped entirely for the affected register. An MTC0 to a register that the exception does not touch (e.g. Compare) still commits.
- int_req (combinational) = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]).
- int_req is a request only. Entry is signalled back via exc_valid with exc_code=0.

Test Plan:
- Reset → cp0_read_data at addr 8'h60 = 32'h0040_0000; Cause=0; int_req=0. Assert rst_n mid-count → Count=0 immediately.
- MTC0 Status=32'hFFFF_FFFF → Status reads 32'h0040_FF03. MTC0 Cause=32'hFFFF_FFFF → Cause reads 32'h0000_0300. With IE=1, EXL=0, IM=FF, int_req=1.
- Compare=5, Count=0, COUNT_DIV=2 → TI=1 about 10 cycles later, Cause[30]=1, Cause[15]=1. Write Compare=100 → TI=0 next cycle.
- exc_valid, code=4, pc=32'hBFC0_0104, delay slot=1, badvaddr=32'h0000_0003 → EPC=32'hBFC0_0100, BD=1, ExcCode=4, BadVAddr=3, EXL=1.
  - Second exception, pc=32'h8000_0200 → EPC unchanged.
- Same cycle exc_valid=1 and eret=1 → EXL=1. Next cycle eret alone → EXL=0.
- Same cycle MTC0 EPC=32'h1234 and exc_valid (EXL=0, pc=32'h80) → EPC=32'h80.
